// File: rtl/blink_meter.sv
// Blink meter: synchronises a slow on/off waveform and reports the high and low
// phase lengths of each completed period, flagging counter saturation.
module blink_meter #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             valid,
    output logic             ovf,
    output logic             stuck
);

    localparam logic [1:0] WAIT = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             s1_q, s2_q, s3_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_hold_q, hi_hold_d;
    logic             ovf_hi_q, ovf_hi_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] low_time_q, low_time_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             rise, fall;
    logic [CNT_W-1:0] cnt_inc;

    // Synchroniser resets to 1 so an input held high through reset yields no rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    assign cnt_inc = (cnt_q == MAX) ? MAX : cnt_q + ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_hold_d   = hi_hold_q;
        ovf_hi_d    = ovf_hi_q;
        high_time_d = high_time_q;
        low_time_d  = low_time_q;
        ovf_d       = ovf_q;
        valid_d     = 1'b0;
        case (state_q)
            WAIT: begin
                if (rise) begin
                    cnt_d   = ONE;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    hi_hold_d = cnt_q;
                    cnt_d     = ONE;
                    state_d   = LOW;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MAX) begin
                        ovf_hi_d = 1'b1;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    high_time_d = hi_hold_q;
                    low_time_d  = cnt_q;
                    ovf_d       = ovf_hi_q | (cnt_q == MAX);
                    ovf_hi_d    = 1'b0;
                    valid_d     = 1'b1;
                    cnt_d       = ONE;
                    state_d     = HIGH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d  = WAIT;
                cnt_d    = '0;
                ovf_hi_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT;
            cnt_q       <= '0;
            hi_hold_q   <= '0;
            ovf_hi_q    <= 1'b0;
            high_time_q <= '0;
            low_time_q  <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_hold_q   <= hi_hold_d;
            ovf_hi_q    <= ovf_hi_d;
            high_time_q <= high_time_d;
            low_time_q  <= low_time_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign high_time = high_time_q;
    assign low_time  = low_time_q;
    assign valid     = valid_q;
    assign ovf       = ovf_q;
    assign stuck     = (state_q != WAIT) && (cnt_q == MAX);

endmodule
